// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight write scoreboard driving decode stall and EX bubble insertion
module hazard_scoreboard #(
    parameter int DEPTH     = 3,
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic [2:0]  id_rd,
    input  logic        id_rs_valid,
    input  logic        id_rt_valid,
    input  logic        id_rd_valid,
    input  logic        flush,
    input  logic        freeze,
    output logic        stall,
    output logic        ex_bubble,
    output logic [7:0]  pend_mask,
    output logic [15:0] stall_count
);

    // The WB slot is invisible to decode when the register file bypasses internally.
    localparam int NCHK = RF_BYPASS ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0]       slot_v;
    logic [DEPTH-1:0][2:0]  slot_reg;
    logic [15:0]            count_q;
    logic                   match_rs;
    logic                   match_rt;
    logic                   hazard;
    logic                   issue;

    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        for (int k = 0; k < NCHK; k++) begin
            if (slot_v[k] && (slot_reg[k] == id_rs)) match_rs = 1'b1;
            if (slot_v[k] && (slot_reg[k] == id_rt)) match_rt = 1'b1;
        end
        hazard = id_valid && ((match_rs && id_rs_valid) || (match_rt && id_rt_valid));
    end

    always_comb begin
        stall     = 1'b0;
        ex_bubble = 1'b0;
        issue     = 1'b0;
        if (freeze) begin
            stall = 1'b1;
        end else if (flush) begin
            ex_bubble = 1'b1;
        end else if (hazard) begin
            stall     = 1'b1;
            ex_bubble = 1'b1;
        end else begin
            issue = 1'b1;
        end
    end

    always_comb begin
        pend_mask = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_v[k]) pend_mask[slot_reg[k]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v   <= '0;
            slot_reg <= '0;
            count_q  <= 16'h0000;
        end else if (!freeze) begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_v[k]   <= slot_v[k-1];
                slot_reg[k] <= slot_reg[k-1];
            end
            slot_v[0]   <= issue && id_valid && id_rd_valid;
            slot_reg[0] <= issue ? id_rd : 3'd0;
            if (!flush && hazard && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign stall_count = count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  id_rs = 3'd0;
    logic [2:0]  id_rt = 3'd0;
    logic [2:0]  id_rd = 3'd0;
    logic        id_rs_valid = 1'b0;
    logic        id_rt_valid = 1'b0;
    logic        id_rd_valid = 1'b0;
    logic        flush = 1'b0;
    logic        freeze = 1'b0;

    logic        b1_stall, b1_bubble, b0_stall, b0_bubble, s_stall, s_bubble;
    logic [7:0]  b1_pend, b0_pend, s_pend;
    logic [15:0] b1_cnt, b0_cnt, s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(1'b1)) dut_b1 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .id_rd_valid(id_rd_valid),
        .flush(flush), .freeze(freeze),
        .stall(b1_stall), .ex_bubble(b1_bubble), .pend_mask(b1_pend), .stall_count(b1_cnt)
    );

    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(1'b0)) dut_b0 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .id_rd_valid(id_rd_valid),
        .flush(flush), .freeze(freeze),
        .stall(b0_stall), .ex_bubble(b0_bubble), .pend_mask(b0_pend), .stall_count(b0_cnt)
    );

    // Deep, fully-checked instance keeps a self-dependent loop stalling 16 of every 17 cycles.
    hazard_scoreboard #(.DEPTH(16), .RF_BYPASS(1'b0)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .id_rd_valid(id_rd_valid),
        .flush(flush), .freeze(freeze),
        .stall(s_stall), .ex_bubble(s_bubble), .pend_mask(s_pend), .stall_count(s_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [2:0] rs, input logic rsv,
                             input logic [2:0] rt, input logic rtv,
                             input logic [2:0] rd, input logic rdv);
        id_valid = v;
        id_rs = rs; id_rs_valid = rsv;
        id_rt = rt; id_rt_valid = rtv;
        id_rd = rd; id_rd_valid = rdv;
    endtask

    task automatic do_reset();
        set_instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        flush = 1'b0;
        freeze = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (b1_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", b1_stall); end
        checks++; if (b1_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b exp 0", b1_bubble); end
        checks++; if (b1_pend !== 8'h00) begin errors++; $display("FAIL reset_pend got %h exp 00", b1_pend); end
        checks++; if (b1_cnt !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", b1_cnt); end
        flush = 1'b1;
        #1;
        checks++; if (b1_bubble !== 1'b1) begin errors++; $display("FAIL reset_flush_bubble got %b exp 1", b1_bubble); end
        freeze = 1'b1;
        #1;
        checks++; if (b1_stall !== 1'b1) begin errors++; $display("FAIL reset_freeze_stall got %b exp 1", b1_stall); end
        checks++; if (b1_bubble !== 1'b0) begin errors++; $display("FAIL reset_freeze_bubble got %b exp 0", b1_bubble); end
        do_reset();
    endtask

    task automatic test_dependent();
        do_reset();
        set_instr(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1);   // ADD R3,R1,R2
        #1;
        checks++; if (b1_stall !== 1'b0) begin errors++; $display("FAIL dep_first_stall got %b exp 0", b1_stall); end
        tick();
        checks++; if (b1_pend !== 8'h08) begin errors++; $display("FAIL dep_pend got %h exp 08", b1_pend); end
        checks++; if (b0_pend !== 8'h08) begin errors++; $display("FAIL dep_pend_nb got %h exp 08", b0_pend); end
        set_instr(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1);   // ADD R4,R3,R3
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if ({b1_stall, b1_bubble} !== 2'b11) begin errors++; $display("FAIL dep_stall%0d got %b exp 11", c, {b1_stall, b1_bubble}); end
            checks++; if (b0_stall !== 1'b1) begin errors++; $display("FAIL dep_stall_nb%0d got %b exp 1", c, b0_stall); end
            tick();
        end
        checks++; if ({b1_stall, b1_bubble} !== 2'b00) begin errors++; $display("FAIL dep_issue got %b exp 00", {b1_stall, b1_bubble}); end
        checks++; if (b1_cnt !== 16'd2) begin errors++; $display("FAIL dep_count got %0d exp 2", b1_cnt); end
        checks++; if (b0_stall !== 1'b1) begin errors++; $display("FAIL dep_stall_nb2 got %b exp 1", b0_stall); end
        tick();
        checks++; if (b1_pend !== 8'h10) begin errors++; $display("FAIL dep_pend_r4 got %h exp 10", b1_pend); end
        checks++; if (b0_stall !== 1'b0) begin errors++; $display("FAIL dep_issue_nb got %b exp 0", b0_stall); end
        checks++; if (b0_cnt !== 16'd3) begin errors++; $display("FAIL dep_count_nb got %0d exp 3", b0_cnt); end
        checks++; if (b1_cnt !== 16'd2) begin errors++; $display("FAIL dep_count_hold got %0d exp 2", b1_cnt); end
    endtask

    task automatic test_independent();
        logic [7:0] exp_pend [6];
        exp_pend = '{8'h02, 8'h06, 8'h0E, 8'h0C, 8'h08, 8'h00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1);
                1: set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
                2: set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
                3: set_instr(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0);
                4: set_instr(1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0);
                default: set_instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
            endcase
            #1;
            checks++; if ((b1_stall | b0_stall) !== 1'b0) begin errors++; $display("FAIL indep_stall%0d got %b/%b exp 0", i, b1_stall, b0_stall); end
            tick();
            checks++; if (b1_pend !== exp_pend[i]) begin errors++; $display("FAIL indep_pend%0d got %h exp %h", i, b1_pend, exp_pend[i]); end
            checks++; if (b0_pend !== exp_pend[i]) begin errors++; $display("FAIL indep_pend_nb%0d got %h exp %h", i, b0_pend, exp_pend[i]); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
        tick();
        set_instr(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1);
        flush = 1'b1;
        #1;
        checks++; if ({b1_stall, b1_bubble} !== 2'b01) begin errors++; $display("FAIL flush_out got %b exp 01", {b1_stall, b1_bubble}); end
        tick();
        flush = 1'b0;
        set_instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        checks++; if (b1_pend !== 8'h04) begin errors++; $display("FAIL flush_pend got %h exp 04", b1_pend); end
        checks++; if (b1_cnt !== 16'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", b1_cnt); end
    endtask

    task automatic test_freeze();
        do_reset();
        set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1);
        tick();
        set_instr(1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 3'd1, 1'b1);   // JAL-style read of R7 on Rt
        freeze = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if ({b1_stall, b1_bubble} !== 2'b10) begin errors++; $display("FAIL freeze_out%0d got %b exp 10", c, {b1_stall, b1_bubble}); end
            tick();
            checks++; if (b1_pend !== 8'h80) begin errors++; $display("FAIL freeze_pend%0d got %h exp 80", c, b1_pend); end
            checks++; if (b1_cnt !== 16'd0) begin errors++; $display("FAIL freeze_count%0d got %0d exp 0", c, b1_cnt); end
        end
        freeze = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if ({b1_stall, b1_bubble} !== 2'b11) begin errors++; $display("FAIL thaw_stall%0d got %b exp 11", c, {b1_stall, b1_bubble}); end
            tick();
        end
        checks++; if (b1_stall !== 1'b0) begin errors++; $display("FAIL thaw_issue got %b exp 0", b1_stall); end
        checks++; if (b1_cnt !== 16'd2) begin errors++; $display("FAIL thaw_count got %0d exp 2", b1_cnt); end
        checks++; if (b1_pend !== 8'h80) begin errors++; $display("FAIL thaw_pend_wb got %h exp 80", b1_pend); end
        tick();
        checks++; if (b1_pend !== 8'h02) begin errors++; $display("FAIL thaw_pend_r1 got %h exp 02", b1_pend); end
    endtask

    task automatic test_saturate();
        do_reset();
        set_instr(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1);   // R1 <- f(R1), repeated
        repeat (17 * 4095) tick();
        checks++; if (s_cnt !== 16'hFFF0) begin errors++; $display("FAIL sat_fff0 got %h exp FFF0", s_cnt); end
        repeat (15) tick();
        checks++; if (s_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %h exp FFFE", s_cnt); end
        tick();
        checks++; if (s_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %h exp FFFF", s_cnt); end
        tick();
        checks++; if (s_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp FFFF", s_cnt); end
        tick();
        tick();
        checks++; if (s_stall !== 1'b1) begin errors++; $display("FAIL sat_midstall got %b exp 1", s_stall); end
        checks++; if (s_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold2 got %h exp FFFF", s_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (s_cnt !== 16'h0000) begin errors++; $display("FAIL rst_count got %h exp 0000", s_cnt); end
        checks++; if (s_pend !== 8'h00) begin errors++; $display("FAIL rst_pend got %h exp 00", s_pend); end
        checks++; if (s_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", s_stall); end
        rst = 1'b1;
        #1;
        checks++; if (s_stall !== 1'b0) begin errors++; $display("FAIL post_rst_issue got %b exp 0", s_stall); end
        tick();
        checks++; if (s_pend !== 8'h02) begin errors++; $display("FAIL post_rst_pend got %h exp 02", s_pend); end
        checks++; if (s_cnt !== 16'h0000) begin errors++; $display("FAIL post_rst_count got %h exp 0000", s_cnt); end
    endtask

    initial begin
        #3;
        test_reset();
        test_dependent();
        test_independent();
        test_flush();
        test_freeze();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
